// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM with a registered,
// read-first read port. Presents first-word-fall-through valid/ready streams on both sides.
module sync_fifo_ctrl #(
  parameter int unsigned P_DEPTH  = 1024,
  parameter int unsigned P_WIDTH  = 8,
  parameter int unsigned P_AFULL  = 1020,
  parameter int unsigned P_AEMPTY = 4,
  localparam int unsigned AW      = $clog2(P_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [P_WIDTH-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [P_WIDTH-1:0] m_data,
  output logic               ram_wr_en,
  output logic [AW-1:0]      ram_wr_addr,
  output logic [P_WIDTH-1:0] ram_wr_data,
  output logic [AW-1:0]      ram_rd_addr,
  input  logic [P_WIDTH-1:0] ram_rd_data,
  output logic [AW:0]        count,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow
);

  localparam logic [AW:0] DepthC  = (AW+1)'(P_DEPTH);
  localparam logic [AW:0] AFullC  = (AW+1)'(P_AFULL);
  localparam logic [AW:0] AEmptyC = (AW+1)'(P_AEMPTY);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   readable_d;
  logic          m_valid_q, s_ready_q, afull_q, aempty_q, overflow_q;
  logic          push, pop, clear;

  always_comb begin
    clear   = rst | flush;
    push    = s_valid & s_ready_q & ~clear;
    pop     = m_valid_q & m_ready & ~clear;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // A word written on this edge is not readable until the edge after, since the
    // read-first RAM returns stale data for a same-cycle address collision.
    readable_d = count_q - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_valid_q  <= 1'b0;
      s_ready_q  <= 1'b1;
      afull_q    <= (P_AFULL == 0);
      aempty_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      m_valid_q  <= (readable_d != '0);
      s_ready_q  <= (count_d < DepthC);
      afull_q    <= (count_d >= AFullC);
      aempty_q   <= (count_d <= AEmptyC);
      overflow_q <= overflow_q | (s_valid & ~s_ready_q);
    end
  end

  always_comb begin
    s_ready      = s_ready_q;
    m_valid      = m_valid_q;
    m_data       = ram_rd_data;
    ram_wr_en    = push;
    ram_wr_addr  = wr_ptr_q;
    ram_wr_data  = s_data;
    // Look ahead on pop so the RAM presents the new head on the next cycle.
    ram_rd_addr  = rd_ptr_q + AW'(pop);
    count        = count_q;
    almost_full  = afull_q;
    almost_empty = aempty_q;
    overflow     = overflow_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a read-first RAM model, a directed vector table and a
// queue-based reference model exercised with fill, wrap, random and flush traffic.
module tb_sync_fifo_ctrl;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned AFULL  = 1020;
  localparam int unsigned AEMPTY = 4;
  localparam int unsigned AW     = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             ram_wr_en;
  logic [AW-1:0]    ram_wr_addr;
  logic [WIDTH-1:0] ram_wr_data;
  logic [AW-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data = '0;
  logic [AW:0]      count;
  logic             almost_full, almost_empty, overflow;

  sync_fifo_ctrl #(
    .P_DEPTH (DEPTH),
    .P_WIDTH (WIDTH),
    .P_AFULL (AFULL),
    .P_AEMPTY(AEMPTY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Registered, read-first dual-port RAM.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  // Reference model: queue of accepted words tagged with the cycle they were accepted.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               tag;
  } entry_t;

  entry_t q[$];
  int     cyc = 0;
  bit     ov_m = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;
  int     n_pop = 0;

  task automatic check(input string name, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a falling edge; advances one full clock.
  task automatic step(input logic sv, input logic [WIDTH-1:0] sd, input logic mr,
                      input logic fl, input bit chk);
    int   sz;
    logic e_mv, e_sr, push, pop;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    #1;
    sz   = q.size();
    e_sr = (sz < int'(DEPTH));
    // Head becomes visible two cycles after it was accepted.
    e_mv = (sz > 0) && (cyc - q[0].tag >= 2);
    push = sv & e_sr & ~fl & ~rst;
    pop  = mr & e_mv & ~fl & ~rst;
    if (chk) begin
      n_vec++;
      check("count", int'(count), sz);
      check("s_ready", int'(s_ready), int'(e_sr));
      check("m_valid", int'(m_valid), int'(e_mv));
      if (e_mv) check("m_data", int'(m_data), int'(q[0].data));
      check("almost_full", int'(almost_full), int'(sz >= int'(AFULL)));
      check("almost_empty", int'(almost_empty), int'(sz <= int'(AEMPTY)));
      check("overflow", int'(overflow), int'(ov_m));
      check("ram_wr_en", int'(ram_wr_en), int'(push));
    end
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
      ov_m = 1'b0;
    end else begin
      if (sv && !e_sr) ov_m = 1'b1;
      if (pop) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (push) q.push_back('{data: sd, tag: cyc});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic             sv;
    logic [WIDTH-1:0] sd;
    logic             mr;
    logic             fl;
    int               e_count;
    logic             e_mv;
    logic [WIDTH-1:0] e_data;
  } vec_t;

  vec_t vt[16];

  initial begin
    // Expected outputs are those seen before the clock edge of that row.
    vt[0]  = '{1, 8'hA5, 0, 0, 0, 0, 8'h00};
    vt[1]  = '{0, 8'h00, 1, 0, 1, 0, 8'h00};  // N+1: not yet visible
    vt[2]  = '{0, 8'h00, 1, 0, 1, 1, 8'hA5};  // N+2: visible, popped
    vt[3]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00};
    vt[4]  = '{1, 8'h11, 0, 0, 0, 0, 8'h00};
    vt[5]  = '{1, 8'h22, 1, 0, 1, 0, 8'h00};  // m_ready ignored while empty
    vt[6]  = '{0, 8'h00, 1, 0, 2, 1, 8'h11};
    vt[7]  = '{0, 8'h00, 1, 0, 1, 1, 8'h22};
    vt[8]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00};
    vt[9]  = '{1, 8'h33, 0, 0, 0, 0, 8'h00};
    vt[10] = '{1, 8'h44, 0, 1, 1, 0, 8'h00};  // flush drops push
    vt[11] = '{0, 8'h00, 0, 0, 0, 0, 8'h00};
    vt[12] = '{1, 8'h3C, 0, 0, 0, 0, 8'h00};
    vt[13] = '{0, 8'h00, 1, 0, 1, 0, 8'h00};
    vt[14] = '{0, 8'h00, 1, 0, 1, 1, 8'h3C};
    vt[15] = '{0, 8'h00, 0, 0, 0, 0, 8'h00};

    @(negedge clk);
    do_reset();
    #1;
    n_vec++;
    check("rst s_ready", int'(s_ready), 1);
    check("rst m_valid", int'(m_valid), 0);
    check("rst count", int'(count), 0);
    check("rst almost_empty", int'(almost_empty), 1);
    check("rst almost_full", int'(almost_full), 0);
    check("rst overflow", int'(overflow), 0);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      check($sformatf("vec%0d count", i), int'(count), vt[i].e_count);
      check($sformatf("vec%0d m_valid", i), int'(m_valid), int'(vt[i].e_mv));
      if (vt[i].e_mv) check($sformatf("vec%0d m_data", i), int'(m_data), int'(vt[i].e_data));
      step(vt[i].sv, vt[i].sd, vt[i].mr, vt[i].fl, 1'b1);
    end

    // Fill to full, then one extra write must set overflow.
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_vec++;
    check("full count", int'(count), int'(DEPTH));
    check("full overflow", int'(overflow), 1);
    check("full s_ready", int'(s_ready), 0);
    // Pop on the full cycle re-opens s_ready one cycle later.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Half fill, then sustained push+pop across pointer wrap.
    do_reset();
    for (int i = 0; i < 512; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) step(1'b1, WIDTH'(i + 512), 1'b1, 1'b0, 1'b1);
    n_vec++;
    check("steady count", int'(count), 512);

    // Random traffic until 10k words are popped, with a cycle budget.
    do_reset();
    n_pop = 0;
    for (int c = 0; c < 60000 && n_pop < 10000; c++)
      step(1'($urandom_range(1)), WIDTH'($urandom), 1'($urandom_range(1)), 1'b0, 1'b1);
    n_vec++;
    if (n_pop < 10000) begin
      n_err++;
      $display("FAIL random timeout: got %0d pops, expected 10000", n_pop);
    end

    // Flush mid-stream with a push active.
    do_reset();
    for (int i = 0; i < 37; i++) step(1'b1, WIDTH'(i + 7), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    n_vec++;
    check("flush count", int'(count), 0);
    check("flush m_valid", int'(m_valid), 0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    n_vec++;
    check("post-flush m_data", int'(m_data), 'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
